sdram_dmi_sched: RTL

- Controller and scheduler between the SoC AXI4 slave port of the SDRAM subsystem and the DDR controller DMI user interface.
- Arbitrates AXI read and write requests round-robin.
- Converts each accepted burst into exactly one 256-bit DMI read or write command:
  - writes are packed, with byte masks, into one DMI word;
  - reads are unpacked from one DMI word into 32-bit beats.
- Sits inside the SDRAM top wrapper, directly in front of the DDR controller.

---
 rtl/sdram_dmi_sched.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_dmi_sched.sv
`default_nettype none
// ============================================================================
// Module  : sdram_dmi_sched
// Brief   : AXI4 slave to DDR DMI scheduler. Round-robin R/W arbitration and
//           one 256-bit DMI command per AXI burst. Optional read watchdog is
//           enabled by defining SDRAM_DMI_RD_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_dmi_sched #(
  parameter int AXI_ID_W   = 4,
  parameter int DMI_ADDR_W = 29,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_awvalid,
  output logic                  in_awready,
  input  logic [31:0]           in_awaddr,
  input  logic [AXI_ID_W-1:0]   in_awid,
  input  logic [7:0]            in_awlen,
  input  logic [2:0]            in_awsize,
  input  logic [1:0]            in_awburst,
  input  logic                  in_wvalid,
  output logic                  in_wready,
  input  logic [31:0]           in_wdata,
  input  logic [3:0]            in_wstrb,
  input  logic                  in_wlast,
  output logic                  in_bvalid,
  input  logic                  in_bready,
  output logic [1:0]            in_bresp,
  output logic [AXI_ID_W-1:0]   in_bid,
  input  logic                  in_arvalid,
  output logic                  in_arready,
  input  logic [31:0]           in_araddr,
  input  logic [AXI_ID_W-1:0]   in_arid,
  input  logic [7:0]            in_arlen,
  input  logic [2:0]            in_arsize,
  input  logic [1:0]            in_arburst,
  output logic                  in_rvalid,
  input  logic                  in_rready,
  output logic [31:0]           in_rdata,
  output logic [1:0]            in_rresp,
  output logic                  in_rlast,
  output logic [AXI_ID_W-1:0]   in_rid,
  output logic [2:0]            dmi_cmd,
  output logic                  dmi_cmd_en,
  output logic [DMI_ADDR_W-1:0] dmi_addr,
  output logic [255:0]          dmi_wr_data,
  output logic                  dmi_wr_data_en,
  output logic                  dmi_wr_data_end,
  output logic [31:0]           dmi_wr_data_mask,
  input  logic                  dmi_init_calib_complete,
  input  logic                  dmi_cmd_ready,
  input  logic                  dmi_wr_data_rdy,
  input  logic [255:0]          dmi_rd_data,
  input  logic                  dmi_rd_data_valid
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WDATA  = 4'd1,
    S_WCMD   = 4'd2,
    S_WDRAIN = 4'd3,
    S_WRESP  = 4'd4,
    S_RCMD   = 4'd5,
    S_RWAIT  = 4'd6,
    S_RBEAT  = 4'd7,
    S_RERR   = 4'd8
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_rr;      // 0: read wins a tie, 1: write wins
  logic [AXI_ID_W-1:0]   r_id;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_lane0;
  logic                  r_err;
  logic [DMI_ADDR_W-1:0] r_addr;
  logic [255:0]          r_wdata;
  logic [31:0]           r_mask;
  logic [255:0]          r_rdbuf;

  logic                  w_grant, w_gnt_rd, w_legal, w_beat_last, w_wfire;
  logic [29:0]           w_sel_addr;
  logic [7:0]            w_sel_len;
  logic [2:0]            w_sel_size;
  logic [1:0]            w_sel_burst;
  logic [2:0]            w_lane;
  logic                  w_unused;

  // Reset is folded in so no READY can appear while reset is held.
  assign w_grant     = dmi_init_calib_complete && !reset && (in_arvalid || in_awvalid);
  assign w_gnt_rd    = in_arvalid && (!in_awvalid || !r_rr);
  assign w_sel_addr  = w_gnt_rd ? in_araddr[29:0] : in_awaddr[29:0];
  assign w_sel_len   = w_gnt_rd ? in_arlen   : in_awlen;
  assign w_sel_size  = w_gnt_rd ? in_arsize  : in_awsize;
  assign w_sel_burst = w_gnt_rd ? in_arburst : in_awburst;
  assign w_legal     = (w_sel_size == 3'd2) && (w_sel_burst == 2'b01) &&
                       (w_sel_addr[1:0] == 2'b00) &&
                       (({6'd0, w_sel_addr[4:2]} + {1'b0, w_sel_len}) <= 9'd7);
  assign w_beat_last = (r_beat == r_len);
  assign w_lane      = r_lane0 + r_beat[2:0];
  assign w_wfire     = dmi_cmd_ready && dmi_wr_data_rdy;

  assign dmi_wr_data      = r_wdata;
  assign dmi_wr_data_mask = r_mask;
  assign w_unused = ^{in_wlast, in_awaddr[31:30], in_araddr[31:30], RD_TIMEOUT[0]};

`ifdef SDRAM_DMI_RD_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
  logic [TMO_W-1:0] r_tcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  r_tcnt <= '0;
    else if (r_state == S_RWAIT) r_tcnt <= r_tcnt + TMO_W'(1);
    else                        r_tcnt <= '0;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    in_awready      = 1'b0;
    in_arready      = 1'b0;
    in_wready       = 1'b0;
    in_bvalid       = 1'b0;
    in_bresp        = 2'b00;
    in_bid          = '0;
    in_rvalid       = 1'b0;
    in_rdata        = '0;
    in_rresp        = 2'b00;
    in_rlast        = 1'b0;
    in_rid          = '0;
    dmi_cmd         = 3'b000;
    dmi_cmd_en      = 1'b0;
    dmi_addr        = '0;
    dmi_wr_data_en  = 1'b0;
    dmi_wr_data_end = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_grant) begin
        in_arready = w_gnt_rd;
        in_awready = !w_gnt_rd;
        if (w_gnt_rd) w_state_nxt = w_legal ? S_RCMD  : S_RERR;
        else          w_state_nxt = w_legal ? S_WDATA : S_WDRAIN;
      end
      S_WDATA, S_WDRAIN: begin
        in_wready = 1'b1;
        if (in_wvalid && w_beat_last)
          w_state_nxt = (r_state == S_WDATA) ? S_WCMD : S_WRESP;
      end
      S_WCMD: begin
        dmi_addr        = r_addr;
        dmi_cmd_en      = w_wfire;
        dmi_wr_data_en  = w_wfire;
        dmi_wr_data_end = w_wfire;
        if (w_wfire) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        in_bvalid = 1'b1;
        in_bid    = r_id;
        in_bresp  = r_err ? 2'b10 : 2'b00;
        if (in_bready) w_state_nxt = S_IDLE;
      end
      S_RCMD: begin
        dmi_cmd    = 3'b001;
        dmi_addr   = r_addr;
        dmi_cmd_en = dmi_cmd_ready;
        if (dmi_cmd_ready) w_state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        if (dmi_rd_data_valid) w_state_nxt = S_RBEAT;
`ifdef SDRAM_DMI_RD_TIMEOUT_EN
        else if (r_tcnt == TMO_LAST) w_state_nxt = S_RERR;
`endif
      end
      S_RBEAT, S_RERR: begin
        in_rvalid = 1'b1;
        in_rid    = r_id;
        in_rlast  = w_beat_last;
        if (r_state == S_RBEAT) in_rdata = r_rdbuf[{w_lane, 5'd0} +: 32];
        else                    in_rresp = 2'b10;
        if (in_rready && w_beat_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr    <= 1'b0;
      r_id    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_lane0 <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_rdbuf <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_grant) begin
          r_rr    <= w_gnt_rd;
          r_id    <= w_gnt_rd ? in_arid : in_awid;
          r_len   <= w_sel_len;
          r_lane0 <= w_sel_addr[4:2];
          r_addr  <= DMI_ADDR_W'({w_sel_addr[29:5], 4'b0000});
          r_beat  <= '0;
          r_err   <= !w_legal;
          if (!w_gnt_rd) begin
            r_wdata <= '0;
            r_mask  <= '1;
          end
        end
        S_WDATA: if (in_wvalid) begin
          r_wdata[{w_lane, 5'd0} +: 32] <= in_wdata;
          for (int j = 0; j < 4; j++)
            if (in_wstrb[j]) r_mask[{w_lane, 2'(j)}] <= 1'b0;
          r_beat <= w_beat_last ? 8'd0 : r_beat + 8'd1;
        end
        S_WDRAIN: if (in_wvalid) r_beat <= w_beat_last ? 8'd0 : r_beat + 8'd1;
        S_RWAIT:  if (dmi_rd_data_valid) r_rdbuf <= dmi_rd_data;
        S_RBEAT, S_RERR: if (in_rready) r_beat <= w_beat_last ? 8'd0 : r_beat + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
